// File: rtl/four_way_arbiter_if.sv
// Joystick arbiter bus: sample strobe, raw/filtered directions and shared mode.
// The master drives the raw side; the arbiter (slave) drives the filtered side.
interface four_way_arbiter_if #(
  parameter int unsigned PLAYERS = 2
);
  logic                   ce;
  logic [4*PLAYERS-1:0]   dirinput;
  logic [3:0]             m_mode;
  logic [4*PLAYERS-1:0]   diroutput;
  logic [PLAYERS-1:0]     diag_active;

  modport master (
    output ce, dirinput, m_mode,
    input  diroutput, diag_active
  );

  modport slave (
    input  ce, dirinput, m_mode,
    output diroutput, diag_active
  );
endinterface

// File: rtl/four_way_arbiter.sv
// Multi-player 4-way joystick filter: cancels opposing directions and resolves
// diagonals by true press order (per-direction saturating press-age counters).
module four_way_arbiter #(
  parameter int unsigned PLAYERS              = 2,
  parameter int unsigned AGE_W                = 8,
  parameter bit          PDIP_FAVOR_DIRECTION = 1'b0
) (
  input  logic               clk_sys,
  input  logic               reset,
  four_way_arbiter_if.slave  bus
);
  localparam int unsigned DIR_W = 4 * PLAYERS;

  localparam logic [3:0] MODE_PREDICTION = 4'd1;
  localparam logic [3:0] MODE_CORRECTION = 4'd2;
  localparam logic [3:0] MODE_VERTICAL   = 4'd3;
  localparam logic [3:0] MODE_HORIZONTAL = 4'd4;
  localparam logic [3:0] MODE_CLEAR      = 4'd5;

  localparam logic [3:0] MASK_V = 4'b1100;
  localparam logic [3:0] MASK_H = 4'b0011;

  wire  [DIR_W-1:0]   w_dir_nxt;
  wire  [PLAYERS-1:0] w_diag_nxt;
  logic               w_enabled;
  logic [DIR_W-1:0]   r_diroutput;
  logic [PLAYERS-1:0] r_diag_active;

  // Unknown mode codes 6..15 behave as DISABLED
  assign w_enabled = (bus.m_mode >= MODE_PREDICTION) && (bus.m_mode <= MODE_CLEAR);

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]       w_raw;
    logic [3:0]       w_c;
    logic [3:0]       w_res;
    logic             w_diag;
    logic             w_diag_on;
    logic             w_keep_v;
    logic [AGE_W-1:0] w_v_age;
    logic [AGE_W-1:0] w_h_age;
    logic [AGE_W-1:0] r_age     [4];
    logic [AGE_W-1:0] w_age_nxt [4];

    assign w_raw = bus.dirinput[4*p +: 4];

    // Post-update ages: saturate while held, clear on release
    always_comb begin
      for (int d = 0; d < 4; d++) begin
        if (!w_raw[d]) begin
          w_age_nxt[d] = '0;
        end else if (&r_age[d]) begin
          w_age_nxt[d] = r_age[d];
        end else begin
          w_age_nxt[d] = r_age[d] + AGE_W'(1);
        end
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_age <= '{default: '0};
      end else if (bus.ce) begin
        r_age <= w_age_nxt;
      end
    end

    always_comb begin
      w_c = w_raw;
      if (w_raw[3] && w_raw[2]) w_c[3:2] = 2'b00;
      if (w_raw[1] && w_raw[0]) w_c[1:0] = 2'b00;
      w_diag  = (|w_c[3:2]) && (|w_c[1:0]);
      w_v_age = w_c[3] ? w_age_nxt[3] : w_age_nxt[2];
      w_h_age = w_c[1] ? w_age_nxt[1] : w_age_nxt[0];

      // Exact ties (incl. both saturated) fall back to the favored axis
      w_keep_v = PDIP_FAVOR_DIRECTION;
      if (w_v_age != w_h_age) begin
        w_keep_v = (bus.m_mode == MODE_PREDICTION) ? (w_v_age < w_h_age)
                                                   : (w_v_age > w_h_age);
      end

      w_res     = w_c;
      w_diag_on = 1'b0;
      if (!w_enabled) begin
        w_res = w_raw;
      end else if (w_diag) begin
        w_diag_on = 1'b1;
        case (bus.m_mode)
          MODE_PREDICTION,
          MODE_CORRECTION: w_res = w_keep_v ? (w_c & MASK_V) : (w_c & MASK_H);
          MODE_VERTICAL:   w_res = w_c & MASK_V;
          MODE_HORIZONTAL: w_res = w_c & MASK_H;
          default:         w_res = 4'b0000;
        endcase
      end
    end

    assign w_dir_nxt[4*p +: 4] = w_res;
    assign w_diag_nxt[p]       = w_diag_on;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_diroutput   <= '0;
      r_diag_active <= '0;
    end else if (bus.ce) begin
      r_diroutput   <= w_dir_nxt;
      r_diag_active <= w_diag_nxt;
    end
  end

  assign bus.diroutput   = r_diroutput;
  assign bus.diag_active = r_diag_active;
endmodule

// File: tb/tb_four_way_arbiter.sv
// Bench for four_way_arbiter: two instances (AGE_W=8/favor H, AGE_W=2/favor V)
// share stimulus and are checked against a press-timestamp reference model.
module tb_four_way_arbiter;
  localparam int unsigned PLAYERS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] dir;
  logic [3:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: sample index at which each direction started being held (-1 = released)
  int         press_t [2][2][4];
  int         n_sample = 0;
  logic [7:0] exp_dir  [2];
  logic [1:0] exp_diag [2];

  four_way_arbiter_if #(.PLAYERS(PLAYERS)) if0 ();
  four_way_arbiter_if #(.PLAYERS(PLAYERS)) if1 ();

  assign if0.ce = ce;  assign if0.dirinput = dir;  assign if0.m_mode = mode;
  assign if1.ce = ce;  assign if1.dirinput = dir;  assign if1.m_mode = mode;

  four_way_arbiter #(.PLAYERS(PLAYERS), .AGE_W(8), .PDIP_FAVOR_DIRECTION(1'b0)) dut0 (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (if0.slave)
  );

  four_way_arbiter #(.PLAYERS(PLAYERS), .AGE_W(2), .PDIP_FAVOR_DIRECTION(1'b1)) dut1 (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic void model_update();
    logic [3:0] raw, c, o;
    int         age [4];
    int         va, ha, maxa;
    bit         fav, keepv, dg;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int p = 0; p < 2; p++)
          for (int d = 0; d < 4; d++) press_t[m][p][d] = -1;
        exp_dir[m]  = '0;
        exp_diag[m] = '0;
      end
    end else if (ce) begin
      n_sample++;
      for (int m = 0; m < 2; m++) begin
        maxa = (m == 0) ? 255 : 3;
        fav  = (m == 1);
        for (int p = 0; p < 2; p++) begin
          raw = dir[4*p +: 4];
          for (int d = 0; d < 4; d++) begin
            if (raw[d]) begin
              if (press_t[m][p][d] < 0) press_t[m][p][d] = n_sample;
              age[d] = n_sample - press_t[m][p][d] + 1;
              if (age[d] > maxa) age[d] = maxa;
            end else begin
              press_t[m][p][d] = -1;
              age[d] = 0;
            end
          end
          dg = 1'b0;
          if (!(mode >= 4'd1 && mode <= 4'd5)) begin
            o = raw;
          end else begin
            c = raw;
            if (raw[3] && raw[2]) c[3:2] = 2'b00;
            if (raw[1] && raw[0]) c[1:0] = 2'b00;
            if (c[3:2] != 2'b00 && c[1:0] != 2'b00) begin
              dg = 1'b1;
              va = c[3] ? age[3] : age[2];
              ha = c[1] ? age[1] : age[0];
              case (mode)
                4'd1:    keepv = (va == ha) ? fav : (va < ha);
                4'd2:    keepv = (va == ha) ? fav : (va > ha);
                4'd3:    keepv = 1'b1;
                default: keepv = 1'b0;
              endcase
              if (mode == 4'd5) o = 4'b0000;
              else              o = keepv ? (c & 4'b1100) : (c & 4'b0011);
            end else begin
              o = c;
            end
          end
          exp_dir[m][4*p +: 4] = o;
          exp_diag[m][p]       = dg;
        end
      end
    end
  endfunction

  // Drive one clock of stimulus, advance the model, then compare both DUTs
  task automatic step(input logic [7:0] d, input logic [3:0] m, input logic c, input logic r);
    dir  = d;
    mode = m;
    ce   = c;
    rst  = r;
    model_update();
    @(posedge clk);
    #1;
    check("dir_m0",  32'(if0.diroutput),   32'(exp_dir[0]));
    check("diag_m0", 32'(if0.diag_active), 32'(exp_diag[0]));
    check("dir_m1",  32'(if1.diroutput),   32'(exp_dir[1]));
    check("diag_m1", 32'(if1.diag_active), 32'(exp_diag[1]));
  endtask

  logic [3:0] sweep_m    [5] = '{4'd3, 4'd4, 4'd5, 4'd0, 4'd9};
  logic [3:0] sweep_dir  [5] = '{4'b1000, 4'b0001, 4'b0000, 4'b1001, 4'b1001};
  logic       sweep_diag [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [7:0] prev;
    logic [7:0] rd;
    logic [7:0] flip;
    logic [3:0] rm;

    // Reset wins over ce, then all four directions of player 0 cancel
    step(8'hFF, 4'd1, 1'b1, 1'b1);
    step(8'hFF, 4'd1, 1'b1, 1'b1);
    check("rst_dir",  32'(if0.diroutput),   32'h0);
    check("rst_diag", 32'(if0.diag_active), 32'h0);
    step(8'h0F, 4'd1, 1'b1, 1'b0);
    check("cancel_all", 32'(if0.diroutput[3:0]), 32'h0);

    // PREDICTION: right held, then up added -> newest (up) wins
    step(8'h00, 4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(8'h01, 4'd1, 1'b1, 1'b0);
      check("pred_right", 32'(if0.diroutput), 32'h01);
    end
    step(8'h09, 4'd1, 1'b1, 1'b0);
    check("pred_up",    32'(if0.diroutput),   32'h08);
    check("pred_diag",  32'(if0.diag_active), 32'h1);
    check("pred_up_m1", 32'(if1.diroutput),   32'h08);

    // CORRECTION: oldest (right) kept until it is released
    step(8'h00, 4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h01, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h09, 4'd2, 1'b1, 1'b0);
      check("corr_keep", 32'(if0.diroutput), 32'h01);
    end
    step(8'h08, 4'd2, 1'b1, 1'b0);
    check("corr_rel", 32'(if0.diroutput), 32'h08);

    // Simultaneous up+left: tie goes to the favored axis, also when saturated
    step(8'h00, 4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(8'h0A, 4'd1, 1'b1, 1'b0);
      check("tie_fav_h", 32'(if0.diroutput), 32'h02);
      check("tie_fav_v", 32'(if1.diroutput), 32'h08);
    end

    // ce gating: junk between strobes is never seen
    step(8'h00, 4'd3, 1'b1, 1'b1);
    step(8'h09, 4'd3, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        step(8'($urandom), 4'd3, 1'b0, 1'b0);
        check("ce_hold", 32'(if0.diroutput), 32'h08);
      end
      step(8'h09, 4'd3, 1'b1, 1'b0);
      check("ce_sample", 32'(if0.diroutput), 32'h08);
    end

    // Mode sweep with up+right held; a new mode waits for the next ce
    prev = 8'h08;
    for (int i = 0; i < 5; i++) begin
      step(8'h09, sweep_m[i], 1'b0, 1'b0);
      check("sweep_wait", 32'(if0.diroutput), 32'(prev));
      step(8'h09, sweep_m[i], 1'b1, 1'b0);
      check("sweep_dir",  32'(if0.diroutput[3:0]), 32'(sweep_dir[i]));
      check("sweep_diag", 32'(if0.diag_active[0]), 32'(sweep_diag[i]));
      prev = if0.diroutput;
    end

    // Random soak: sticky directions so ages build up, occasional mode/reset changes
    rd = 8'h00;
    rm = 4'd1;
    for (int i = 0; i < 4000; i++) begin
      flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rd   = rd ^ flip;
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       rm = 4'($urandom_range(0, 15));
          1:       rm = 4'd2;
          default: rm = 4'd1;
        endcase
      end
      step(rd, rm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/four_way_arbiter.md
# four_way_arbiter

Registered, multi-player successor to the combinational diagonal filter for 4-way arcade controls. It keeps a per-direction press-age counter for each player. A diagonal is resolved from the true press order, not from the previous output, and opposing directions on one axis are cancelled. It sits between the MiSTer joystick decode and the game input latches, one instance serving all players.

## Interface
- PLAYERS, 2, number of independent joystick channels (1..4)
- AGE_W, 8, width of each saturating press-age counter (2..16)
- PDIP_FAVOR_DIRECTION, 0, axis kept on an exact tie: 0 horizontal, 1 vertical
---
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  sample strobe; all state advances only on cycles with ce=1
- dirinput  in  4*PLAYERS  raw directions; player p at [4p+3:4p] = {up, down, left, right}
- m_mode  in  4  shared mode: 0 DISABLED, 1 PREDICTION, 2 CORRECTION, 3 VERTICAL, 4 HORIZONTAL, 5 CLEAR, 6..15 treated as DISABLED
- diroutput  out  4*PLAYERS  registered filtered directions, same packing as dirinput
- diag_active  out  PLAYERS  registered; 1 while the player's raw input (after opposing-cancel) is diagonal and mode is not DISABLED

## Operation
- Per player, per direction bit d, age[d] (AGE_W bits):
  - On ce, if d is pressed: age = min(age+1, 2^AGE_W-1).
  - On ce, if d is released: age = 0.
  - Age 1 means newly pressed this sample.
- Opposing cancel (mode ≠ DISABLED): if up and down are both pressed, both are dropped. If left and right are both pressed, both are dropped. The result is c.
- Diagonal means c has one vertical bit and one horizontal bit. Define vAge as the age of the vertical bit and hAge as the age of the horizontal bit, both taken after this sample's update.
- Resolution on diagonal:
  - PREDICTION: keep the axis with the smaller age (newest press).
  - CORRECTION: keep the axis with the larger age (oldest press).
  - Tie in either mode (including both saturated): keep the PDIP_FAVOR_DIRECTION axis.
  - VERTICAL: drop the horizontal bit.
  - HORIZONTAL: drop the vertical bit.
  - CLEAR: output 0.
- Non-diagonal c: output c.
- DISABLED / 6..15: output the raw dirinput unchanged, including opposing and diagonal combinations. diag_active = 0.
- Players are fully independent; only m_mode is shared.
- A mode change takes effect on the next ce. Ages are never cleared by a mode change.

## Timing
- Reset (synchronous): all ages = 0, diroutput = 0, diag_active = 0. Reset has priority over ce. Reset mid-hold means a still-held direction restarts at age 1 on the first ce after reset is released.
- Latency: diroutput and diag_active reflect the dirinput sampled on a ce cycle at the next clk_sys edge, i.e. 1 clock. They hold their value while ce=0.
- dirinput changes between ce strobes are invisible. Only the value present on a ce cycle counts.
- Age counter update and resolution use the same sample. The comparison uses post-update ages, so a press on this ce has age 1.
- Two bits pressed on the same ce have equal age, which resolves by PDIP_FAVOR_DIRECTION in PREDICTION and in CORRECTION.
- Saturation: a held bit stops at 2^AGE_W-1 and never wraps.

## Test plan
- Reset with dirinput=all-ones, ce=1 → diroutput=0, diag_active=0. On the first ce after reset release in PREDICTION, player 0 sees up+down+left+right; both axes cancel → diroutput[3:0]=0000.
- PREDICTION, PLAYERS=2, ce every cycle:
  - Sequence: right held 5 samples, then up added.
  - Required: player 0 output goes 0001 then 1000 one clock after up is sampled, and diag_active[0]=1.
  - Player 1 stays 0 throughout.
- CORRECTION, same stimulus → output stays 0001 during the diagonal. When right is released → 1000 one clock later.
- Exact-simultaneous press:
  - Stimulus: up+left on the same ce, PREDICTION.
  - PDIP_FAVOR_DIRECTION=0 → 0010; with 1 → 1000.
  - With AGE_W=2, holding up+left 10 samples (both saturated at 3) → still the favored axis.
- ce gating:
  - Stimulus: pulse ce every 4th clock; toggle dirinput only on non-ce cycles.
  - Required: diroutput never changes and ages stay constant.
- Mode sweep with up+right held:
  - VERTICAL → 1000, HORIZONTAL → 0001, CLEAR → 0000, DISABLED → 1001, m_mode=9 → 1001.
  - Each change is visible one clock after the next ce.
